// File: rtl/mesi_isc_broad_snoop_cntl_if.sv
// Bus bundle between the broadcast FIFO / coherence bus and the snoop controller.
// The slave modport is the controller's view; master is the environment driving it.
interface mesi_isc_broad_snoop_cntl_if #(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7
);
  logic                        broad_fifo_status_empty_i;
  logic [ADDR_WIDTH-1:0]       broad_addr_i;
  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i;
  logic [1:0]                  broad_cpu_id_i;
  logic [BROAD_ID_WIDTH-1:0]   broad_id_i;
  logic [3:0]                  cbus_ack_array_i;
  logic                        broad_fifo_rd_o;
  logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o;
  logic [ADDR_WIDTH-1:0]       cbus_addr_o;
  logic                        broad_done_o;
  logic [BROAD_ID_WIDTH-1:0]   broad_done_id_o;
  logic                        broad_err_o;
  logic                        busy_o;

  modport slave (
    input  broad_fifo_status_empty_i,
    input  broad_addr_i,
    input  broad_type_i,
    input  broad_cpu_id_i,
    input  broad_id_i,
    input  cbus_ack_array_i,
    output broad_fifo_rd_o,
    output cbus_cmd_array_o,
    output cbus_addr_o,
    output broad_done_o,
    output broad_done_id_o,
    output broad_err_o,
    output busy_o
  );

  modport master (
    output broad_fifo_status_empty_i,
    output broad_addr_i,
    output broad_type_i,
    output broad_cpu_id_i,
    output broad_id_i,
    output cbus_ack_array_i,
    input  broad_fifo_rd_o,
    input  cbus_cmd_array_o,
    input  cbus_addr_o,
    input  broad_done_o,
    input  broad_done_id_o,
    input  broad_err_o,
    input  busy_o
  );
endinterface

// File: rtl/mesi_isc_broad_snoop_cntl.sv
// Broadcast snoop controller: pops one broadcast entry, snoops the other three CPUs,
// then enables the initiator and retires the entry with a done/err pulse.
module mesi_isc_broad_snoop_cntl #(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7
) (
  input logic                        clk,
  input logic                        rst,
  mesi_isc_broad_snoop_cntl_if.slave bus
);

  localparam int NUM_CPU   = 4;
  localparam int CMD_ARR_W = NUM_CPU * CBUS_CMD_WIDTH;

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = '0;
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE,
    SNOOP,
    ENABLE,
    POP
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
  logic [1:0]                  cpu_q, cpu_d;
  logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;
  logic [NUM_CPU-1:0]          ack_pending_q, ack_pending_d;
  logic [CMD_ARR_W-1:0]        cmd_q, cmd_d;
  logic                        fifo_rd_q, fifo_rd_d;
  logic                        done_q, done_d;
  logic [BROAD_ID_WIDTH-1:0]   done_id_q, done_id_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;

  logic [NUM_CPU-1:0]          init_mask;
  logic [NUM_CPU-1:0]          pending_after_ack;

  function automatic logic type_valid(input logic [BROAD_TYPE_WIDTH-1:0] t);
    return (t == TYPE_WR) || (t == TYPE_RD);
  endfunction

  function automatic logic [CMD_ARR_W-1:0] snoop_cmds(
    input logic [NUM_CPU-1:0]          mask,
    input logic [BROAD_TYPE_WIDTH-1:0] t
  );
    logic [CMD_ARR_W-1:0] v;
    v = '0;
    for (int j = 0; j < NUM_CPU; j++) begin
      if (mask[j]) begin
        v[j*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (t == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP;
      end
    end
    return v;
  endfunction

  function automatic logic [CMD_ARR_W-1:0] enable_cmd(
    input logic [1:0]                  cpu,
    input logic [BROAD_TYPE_WIDTH-1:0] t
  );
    logic [CMD_ARR_W-1:0] v;
    v = '0;
    v[int'(cpu)*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (t == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD;
    return v;
  endfunction

  // Every CPU except the initiator owes a snoop ack; acks only retire pending bits.
  assign init_mask         = 4'b1111 & ~(4'b0001 << bus.broad_cpu_id_i);
  assign pending_after_ack = ack_pending_q & ~bus.cbus_ack_array_i;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    type_d        = type_q;
    cpu_d         = cpu_q;
    id_d          = id_q;
    ack_pending_d = ack_pending_q;
    cmd_d         = {CMD_ARR_W{1'b0}};
    fifo_rd_d     = 1'b0;
    done_d        = 1'b0;
    done_id_d     = done_id_q;
    err_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.broad_fifo_status_empty_i) begin
          addr_d = bus.broad_addr_i;
          type_d = bus.broad_type_i;
          cpu_d  = bus.broad_cpu_id_i;
          id_d   = bus.broad_id_i;
          if (type_valid(bus.broad_type_i)) begin
            ack_pending_d = init_mask;
            cmd_d         = snoop_cmds(init_mask, bus.broad_type_i);
            state_d       = SNOOP;
          end else begin
            // Invalid entries skip the bus entirely and retire with an error flag.
            ack_pending_d = '0;
            fifo_rd_d     = 1'b1;
            done_d        = 1'b1;
            done_id_d     = bus.broad_id_i;
            err_d         = 1'b1;
            state_d       = POP;
          end
        end
      end

      SNOOP: begin
        ack_pending_d = pending_after_ack;
        if (pending_after_ack == '0) begin
          cmd_d   = enable_cmd(cpu_q, type_q);
          state_d = ENABLE;
        end else begin
          cmd_d = snoop_cmds(pending_after_ack, type_q);
        end
      end

      ENABLE: begin
        if (bus.cbus_ack_array_i[cpu_q]) begin
          fifo_rd_d = 1'b1;
          done_d    = 1'b1;
          done_id_d = id_q;
          err_d     = !type_valid(type_q);
          state_d   = POP;
        end else begin
          cmd_d = enable_cmd(cpu_q, type_q);
        end
      end

      POP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      type_q        <= '0;
      cpu_q         <= '0;
      id_q          <= '0;
      ack_pending_q <= '0;
      cmd_q         <= '0;
      fifo_rd_q     <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      type_q        <= type_d;
      cpu_q         <= cpu_d;
      id_q          <= id_d;
      ack_pending_q <= ack_pending_d;
      cmd_q         <= cmd_d;
      fifo_rd_q     <= fifo_rd_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.broad_fifo_rd_o  = fifo_rd_q;
  assign bus.cbus_cmd_array_o = cmd_q;
  assign bus.cbus_addr_o      = addr_q;
  assign bus.broad_done_o     = done_q;
  assign bus.broad_done_id_o  = done_id_q;
  assign bus.broad_err_o      = err_q;
  assign bus.busy_o           = busy_q;

endmodule
